// File: rtl/seven_seg_scan_controller.sv
// Avalon-MM slave that scans NUM_DIGITS 5-bit digit codes onto one shared
// segment decoder, with a blanking gap between digits to suppress ghosting.
module seven_seg_scan_controller #(
   parameter int          NUM_DIGITS   = 4,
   parameter logic [15:0] DIV_RESET    = 16'd49999,
   parameter int          BLANK_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [3:0]            address,
   input  logic                  chipselect,
   input  logic                  write,
   input  logic                  read,
   input  logic [31:0]           writedata,
   output logic [31:0]           readdata,
   output logic [4:0]            digit_code,
   output logic [NUM_DIGITS-1:0] digit_en_n
);

   localparam logic [1:0]  ST_IDLE    = 2'd0;
   localparam logic [1:0]  ST_BLANK   = 2'd1;
   localparam logic [1:0]  ST_SHOW    = 2'd2;
   localparam logic [4:0]  CODE_BLANK = 5'h10;
   localparam logic [15:0] BLANK_LOAD = 16'(BLANK_CYCLES - 1);
   localparam logic [2:0]  LAST_IDX   = 3'(NUM_DIGITS - 1);

   logic [NUM_DIGITS-1:0][4:0] digit_reg;
   logic                       enable;
   logic [15:0]                divider;
   logic [15:0]                cnt;
   logic [2:0]                 index;
   logic [1:0]                 state;
   logic                       wr_en;
   logic                       rd_en;
   logic [31:0]                rd_mux;
   logic [4:0]                 cur_code;
   logic                       unused_wdata;

   assign wr_en        = chipselect && write;
   assign rd_en        = chipselect && read;
   assign unused_wdata = ^writedata[31:16];

   // Unused digit slots and unmapped addresses fall through to zero.
   always_comb begin
      rd_mux   = '0;
      cur_code = CODE_BLANK;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (address == 4'(i)) rd_mux = {27'd0, digit_reg[i]};
         if (index == 3'(i))   cur_code = digit_reg[i];
      end
      case (address)
         4'd8:    rd_mux = {31'd0, enable};
         4'd9:    rd_mux = {16'd0, divider};
         4'd10:   rd_mux = {28'd0, state == ST_SHOW, index};
         default: ;
      endcase
   end

   // Read mux sees pre-edge registers, so read+write of one register returns the old value.
   always_ff @(posedge clk) begin
      if (reset) begin
         readdata  <= '0;
         digit_reg <= {NUM_DIGITS{CODE_BLANK}};
         enable    <= 1'b0;
         divider   <= DIV_RESET;
      end else begin
         if (rd_en) readdata <= rd_mux;
         if (wr_en) begin
            for (int i = 0; i < NUM_DIGITS; i++)
               if (address == 4'(i)) digit_reg[i] <= writedata[4:0];
            if (address == 4'd8) enable  <= writedata[0];
            if (address == 4'd9) divider <= writedata[15:0];
         end
      end
   end

   // cnt is shared: blank gap countdown in BLANK, dwell countdown in SHOW.
   always_ff @(posedge clk) begin
      if (reset || !enable) begin
         state      <= ST_IDLE;
         index      <= '0;
         cnt        <= '0;
         digit_code <= CODE_BLANK;
         digit_en_n <= '1;
      end else begin
         case (state)
            ST_IDLE: begin
               state <= ST_BLANK;
               index <= '0;
               cnt   <= BLANK_LOAD;
            end
            ST_BLANK: begin
               if (cnt == 16'd0) begin
                  state      <= ST_SHOW;
                  digit_code <= cur_code;
                  digit_en_n <= ~(NUM_DIGITS'(1) << index);
                  cnt        <= divider;
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            ST_SHOW: begin
               if (cnt == 16'd0) begin
                  state      <= ST_BLANK;
                  digit_code <= CODE_BLANK;
                  digit_en_n <= '1;
                  index      <= (index == LAST_IDX) ? 3'd0 : index + 3'd1;
                  cnt        <= BLANK_LOAD;
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            default: begin
               state      <= ST_IDLE;
               digit_code <= CODE_BLANK;
               digit_en_n <= '1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seven_seg_scan_controller.sv
// Scoreboard bench: stimulus queues expected display frames and read data,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_seven_seg_scan_controller;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  address = '0;
   logic        chipselect = 1'b0;
   logic        write = 1'b0;
   logic        read = 1'b0;
   logic [31:0] writedata = '0;
   logic [31:0] readdata;
   logic [4:0]  digit_code;
   logic [3:0]  digit_en_n;

   typedef struct packed {
      logic [4:0] code;
      logic [3:0] en_n;
   } disp_t;

   disp_t       disp_q[$];
   logic [31:0] rd_q[$];
   disp_t       e;
   logic [31:0] rexp;
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   logic        rd_seen = 1'b0;
   int          w0;
   logic [4:0]  codes [4];

   seven_seg_scan_controller #(
      .NUM_DIGITS   (4),
      .DIV_RESET    (16'd49999),
      .BLANK_CYCLES (2)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .address    (address),
      .chipselect (chipselect),
      .write      (write),
      .read       (read),
      .writedata  (writedata),
      .readdata   (readdata),
      .digit_code (digit_code),
      .digit_en_n (digit_en_n)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge clk) begin
      cyc     <= cyc + 1;
      rd_seen <= chipselect && read;
   end

   always @(negedge clk) begin
      if (disp_q.size() > 0) begin
         e = disp_q.pop_front();
         chk("disp_code", 32'(digit_code), 32'(e.code));
         chk("disp_en_n", 32'(digit_en_n), 32'(e.en_n));
      end
      chk("onehot", 32'($countones(~digit_en_n) <= 1), 32'd1);
      if (rd_seen) begin
         if (rd_q.size() == 0) begin
            chk("rd_unexpected", 32'(rd_q.size()), 32'd1);
         end else begin
            rexp = rd_q.pop_front();
            chk("rd", readdata, rexp);
         end
      end
   end

   task automatic push_blank(input int n);
      repeat (n) disp_q.push_back(disp_t'({5'h10, 4'hF}));
   endtask

   task automatic push_show(input logic [4:0] code, input int idx, input int n);
      logic [3:0] en;
      en = ~(4'b0001 << idx);
      repeat (n) disp_q.push_back(disp_t'({code, en}));
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
      @(posedge clk); #1;
      chipselect = 1'b0; write = 1'b0;
   endtask

   task automatic rd(input logic [3:0] a, input logic [31:0] exp);
      rd_q.push_back(exp);
      chipselect = 1'b1; read = 1'b1; address = a;
      @(posedge clk); #1;
      chipselect = 1'b0; read = 1'b0;
   endtask

   task automatic rw(input logic [3:0] a, input logic [31:0] d, input logic [31:0] exp);
      rd_q.push_back(exp);
      chipselect = 1'b1; read = 1'b1; write = 1'b1; address = a; writedata = d;
      @(posedge clk); #1;
      chipselect = 1'b0; read = 1'b0; write = 1'b0;
   endtask

   task automatic wait_until(input int target);
      while (cyc < target) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && disp_q.size() > 0; i++) @(negedge clk);
      if (disp_q.size() > 0) begin
         chk("drain", 32'(disp_q.size()), 32'd0);
         disp_q.delete();
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      // reset state
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      chk("rst_readdata", readdata, 32'd0);
      chk("rst_code", 32'(digit_code), 32'h10);
      chk("rst_en_n", 32'(digit_en_n), 32'hF);
      rd(4'd9, 32'd49999);
      rd(4'd8, 32'd0);

      // normal scan, mid-dwell digit write, mid-SHOW disable
      wr(4'd0, 32'd1); wr(4'd1, 32'd2); wr(4'd2, 32'd3); wr(4'd3, 32'd4);
      wr(4'd9, 32'd3);
      wr(4'd8, 32'd1);
      w0 = cyc;
      push_blank(3);
      for (int r = 0; r < 2; r++)
         for (int d = 0; d < 4; d++) begin
            push_show((r == 1 && d == 1) ? 5'd9 : 5'(d + 1), d, 4);
            push_blank(2);
         end
      push_show(5'd1, 0, 2);
      push_blank(3);
      wait_until(w0 + 9);
      wr(4'd1, 32'd9);
      wait_until(w0 + 16);
      rd(4'd10, 32'd10);
      wait_until(w0 + 51);
      wr(4'd8, 32'd0);
      wait_until(w0 + 53);
      rd(4'd10, 32'd0);
      drain();

      // DIV=0 one-cycle dwell, re-enable restart, unused addresses
      rw(4'd9, 32'd0, 32'd3);
      codes[0] = 5'd1; codes[1] = 5'd9; codes[2] = 5'd3; codes[3] = 5'd4;
      wr(4'd8, 32'd1);
      push_blank(3);
      for (int d = 0; d < 4; d++) begin
         push_show(codes[d], d, 1);
         push_blank(2);
      end
      push_show(5'd1, 0, 1);
      wr(4'd6, 32'h1F);
      wr(4'd12, 32'hFFFF);
      rd(4'd6, 32'd0);
      rd(4'd12, 32'd0);
      rd(4'd0, 32'd1);
      rd(4'd1, 32'd9);
      rd(4'd9, 32'd0);
      rd(4'd8, 32'd1);
      drain();
      wr(4'd8, 32'd0);
      wr(4'd3, 32'hABCD_0014);
      rd(4'd3, 32'h14);
      wr(4'd2, 32'hFFFF_FFE3);
      rd(4'd2, 32'd3);

      // reset during SHOW of digit2
      wr(4'd9, 32'd3);
      wr(4'd8, 32'd1);
      w0 = cyc;
      push_blank(3);
      push_show(5'd1, 0, 4); push_blank(2);
      push_show(5'd9, 1, 4); push_blank(2);
      push_show(5'd3, 2, 1); push_blank(1);
      wait_until(w0 + 15);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("rst2_readdata", readdata, 32'd0);
      rd(4'd9, 32'd49999);
      rd(4'd8, 32'd0);
      rd(4'd0, 32'h10);
      rd(4'd3, 32'h10);
      rd(4'd10, 32'd0);
      drain();
      chk("rd_left", 32'(rd_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seven_seg_scan_controller.md
Name: seven_seg_scan_controller

Overview:
Avalon-MM slave that time-multiplexes NUM_DIGITS seven-segment digits over one shared segment decoder.
- Holds one 5-bit code per digit and sequences them onto a single digit_code bus (0-15 hex, 16 = blank), with active-low digit enables.
- Inserts a blanking gap between digits to suppress ghosting.
- Sits between the Avalon bus fabric and the display decoder/pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits; legal range 2..8.
DIV_RESET, 16'd49999, reset value of the scan divider register; SHOW dwell = divider+1 clk cycles.
BLANK_CYCLES, 16, clk cycles all digits are off between consecutive digits; legal range 1..255.

Ports:
clk  input  1  system clock.
reset  input  1  synchronous, active-high reset.
address  input  4  register word address.
chipselect  input  1  slave select.
write  input  1  write strobe; qualified by chipselect.
read  input  1  read strobe; qualified by chipselect.
writedata  input  32  write data.
readdata  output  32  registered read data.
digit_code  output  5  code to the segment decoder; 5'h10 = blank.
digit_en_n  output  NUM_DIGITS  active-low digit enables; at most one bit low.

Behaviour:
Reset:
- One clock, synchronous, active-high, as stated above.
- Reset values: readdata=0, digit_code=5'h10, digit_en_n=all 1s, every digit register=5'h10, ctrl.enable=0, divider=DIV_RESET, index=0, state=IDLE.

Register map (word addresses):
- 0..NUM_DIGITS-1: DIGITn, R/W, bits[4:0]; upper bits ignored on write, read as 0.
- NUM_DIGITS..7: unused digit slots; writes ignored, read 0.
- 8: CTRL, R/W, bit0 = enable.
- 9: DIV, R/W, bits[15:0].
- 10: STATUS, RO; bits[2:0] = current index, bit3 = 1 when state is SHOW.
- Other addresses: writes ignored, read 0.

Bus timing:
- A write takes effect on the clk edge where chipselect&&write.
- Read latency is 1: readdata is loaded on the edge where chipselect&&read and holds its value otherwise.
- Simultaneous read and write of the same register: readdata returns the old value.

FSM states: IDLE, BLANK, SHOW.
- IDLE:
  - Outputs: digit_en_n all 1s, digit_code=5'h10.
  - When enable=1: next state BLANK, index=0, blank counter loaded with BLANK_CYCLES-1.
- BLANK:
  - Outputs: digit_en_n all 1s, digit_code=5'h10.
  - Counter decrements; at 0, next state SHOW.
  - On the BLANK->SHOW edge:
    - digit_code <= DIGIT[index];
    - digit_en_n <= ~(1<<index);
    - dwell counter <= DIV.
- SHOW:
  - Dwell counter decrements; at 0:
    - next state BLANK, outputs blanked;
    - index <= (index==NUM_DIGITS-1) ? 0 : index+1;
    - blank counter reloaded.
  - Dwell is DIV+1 cycles; DIV=0 gives a 1-cycle dwell.
- enable=0, seen in any state: next edge goes to IDLE with outputs blanked and index=0.

Latching rules:
- DIGITn is sampled only on BLANK->SHOW. A write during SHOW of that digit appears on its next scan; no mid-dwell change.
- A DIV write is used at the next dwell-counter load. A SHOW in progress completes with the old value.

Output rules:
- digit_code and digit_en_n are registered and glitch-free.
- Never two digits enabled at once.
- A digit is never enabled while digit_code is changing.
- Codes 17-31 are passed through unchanged; the downstream decoder shows them as blank.

Test Plan:
1. Assert reset 2 cycles -> readdata=0, digit_code=5'h10, digit_en_n=4'b1111; read addr 9 returns 49999; read addr 8 returns 0.
2. NUM_DIGITS=4, BLANK_CYCLES=2. Write DIGIT0..3=1,2,3,4, DIV=3, CTRL=1 -> repeating pattern of 2 blank cycles then 4 cycles of code 1 with en_n=1110, then codes 2, 3, 4 with en_n=1101, 1011, 0111, then wraps to digit0; never more than one en_n bit low.
3. While digit1 is in SHOW, write DIGIT1=9 -> current dwell keeps code 2; next scan of digit1 shows 9.
4. Mid-SHOW write CTRL=0 -> next edge en_n=1111, code=5'h10, STATUS=0. Re-enable -> scanning restarts at digit0 after a BLANK period.
5. DIV=0 -> each digit shown exactly 1 cycle. Write addr 6 (unused) and addr 12 -> no register changes, and both read back 0 with 1-cycle latency.
6. Assert reset during SHOW of digit2 -> next edge all outputs and registers at reset values, state IDLE.
